// File: rtl/enemy_engine_pkg.sv
// Shared types and constants for the enemy sprite engine.
package enemy_engine_pkg;

   typedef enum logic [2:0] {
      WAIT_TICK,
      ERASE,
      MOVE,
      DRAW,
      NEXT,
      DONE
   } state_t;

   localparam logic [2:0] BLACK          = 3'b000;
   localparam logic [2:0] DEFAULT_COLOUR = 3'b100;

   // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_step(input logic [7:0] value);
      return {value[6:0], ^(value & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/enemy_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used as the spawn randomness source.
module enemy_lfsr
   import enemy_engine_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clock,
   input  logic       resetn,
   output logic [7:0] value
);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         value <= SEED;
      end else begin
         value <= lfsr_step(value);
      end
   end

endmodule

// File: rtl/enemy_engine.sv
// Enemy sprite engine: on each tick, erase, move and redraw every enemy slot
// through a valid/ready pixel port; killed or off-screen enemies respawn at the top.
module enemy_engine
   import enemy_engine_pkg::*;
#(
   parameter int unsigned N_ENEMY     = 4,
   parameter int unsigned SPR_W       = 4,
   parameter int unsigned SPR_H       = 4,
   parameter int unsigned X_MAX       = 160,
   parameter int unsigned Y_MAX       = 120,
   parameter int unsigned TICK_CYCLES = 4500000,
   parameter int unsigned STEP        = 1,
   parameter logic [7:0]  SEED        = 8'hA5
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               enable,
   input  logic [N_ENEMY-1:0] kill,
   input  logic               plot_ready,
   output logic               plot_valid,
   output logic [7:0]         x,
   output logic [6:0]         y,
   output logic [2:0]         colour,
   output logic               frame_done,
   output logic [N_ENEMY-1:0] kill_ack
);

   localparam int unsigned SW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
   localparam int unsigned CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int unsigned RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   localparam logic [TW-1:0] TICK_LOAD  = TW'(TICK_CYCLES - 1);
   localparam logic [SW-1:0] SLOT_LAST  = SW'(N_ENEMY - 1);
   localparam logic [CW-1:0] COL_LAST   = CW'(SPR_W - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(SPR_H - 1);
   localparam logic [7:0]    SPAWN_SPAN = 8'(X_MAX - SPR_W);
   localparam logic [7:0]    Y_LIMIT    = 8'(Y_MAX - SPR_H);
   localparam logic [7:0]    STEP8      = 8'(STEP);

   state_t             state;
   logic [TW-1:0]      count;
   logic [SW-1:0]      slot;
   logic [CW-1:0]      col;
   logic [RW-1:0]      row;
   logic [7:0]         ex   [N_ENEMY];
   logic [6:0]         ey   [N_ENEMY];
   logic [2:0]         ecol [N_ENEMY];
   logic [N_ENEMY-1:0] kill_pend;

   logic [7:0]    lfsr;
   logic [7:0]    spawn_x;
   logic [2:0]    spawn_col;
   logic [7:0]    ey_step;
   logic          respawn;
   logic          last_pix;
   logic [CW-1:0] col_n;
   logic [RW-1:0] row_n;
   logic [SW-1:0] slot_next;

   enemy_lfsr #(
      .SEED(SEED)
   ) u_lfsr (
      .clock (clock),
      .resetn(resetn),
      .value (lfsr)
   );

   always_comb begin
      spawn_x   = (lfsr < SPAWN_SPAN) ? lfsr : lfsr - SPAWN_SPAN;
      spawn_col = (lfsr[2:0] == BLACK) ? 3'b111 : lfsr[2:0];
      // Widened to 8 bits so the bottom-edge test never sees a wrapped row.
      ey_step   = {1'b0, ey[slot]} + STEP8;
      respawn   = kill_pend[slot] | (ey_step > Y_LIMIT);
      last_pix  = (col == COL_LAST) && (row == ROW_LAST);
      slot_next = slot + 1'b1;
      if (col == COL_LAST) begin
         col_n = '0;
         row_n = row + 1'b1;
      end else begin
         col_n = col + 1'b1;
         row_n = row;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= WAIT_TICK;
         count      <= TICK_LOAD;
         slot       <= '0;
         col        <= '0;
         row        <= '0;
         kill_pend  <= '0;
         plot_valid <= 1'b0;
         x          <= '0;
         y          <= '0;
         colour     <= BLACK;
         frame_done <= 1'b0;
         kill_ack   <= '0;
         for (int i = 0; i < N_ENEMY; i++) begin
            ex[i]   <= 8'(i * (X_MAX / N_ENEMY));
            ey[i]   <= '0;
            ecol[i] <= DEFAULT_COLOUR;
         end
      end else begin
         kill_ack   <= '0;
         frame_done <= 1'b0;
         kill_pend  <= kill_pend | kill;
         case (state)
            WAIT_TICK: begin
               if (count == '0) begin
                  state      <= ERASE;
                  slot       <= '0;
                  col        <= '0;
                  row        <= '0;
                  x          <= ex[0];
                  y          <= ey[0];
                  colour     <= BLACK;
                  plot_valid <= 1'b1;
               end else if (enable) begin
                  count <= count - 1'b1;
               end
            end
            ERASE, DRAW: begin
               if (plot_ready) begin
                  if (last_pix) begin
                     plot_valid <= 1'b0;
                     state      <= (state == ERASE) ? MOVE : NEXT;
                  end else begin
                     col <= col_n;
                     row <= row_n;
                     x   <= ex[slot] + 8'(col_n);
                     y   <= ey[slot] + 7'(row_n);
                  end
               end
            end
            MOVE: begin
               // Clearing the pend here also drops any kill arriving this cycle.
               if (respawn) begin
                  ex[slot]        <= spawn_x;
                  ey[slot]        <= '0;
                  ecol[slot]      <= spawn_col;
                  kill_pend[slot] <= 1'b0;
                  kill_ack[slot]  <= kill_pend[slot];
                  x               <= spawn_x;
                  y               <= '0;
                  colour          <= spawn_col;
               end else begin
                  ey[slot] <= ey_step[6:0];
                  x        <= ex[slot];
                  y        <= ey_step[6:0];
                  colour   <= ecol[slot];
               end
               col        <= '0;
               row        <= '0;
               plot_valid <= 1'b1;
               state      <= DRAW;
            end
            NEXT: begin
               if (slot == SLOT_LAST) begin
                  frame_done <= 1'b1;
                  state      <= DONE;
               end else begin
                  slot       <= slot_next;
                  col        <= '0;
                  row        <= '0;
                  x          <= ex[slot_next];
                  y          <= ey[slot_next];
                  colour     <= BLACK;
                  plot_valid <= 1'b1;
                  state      <= ERASE;
               end
            end
            DONE: begin
               count <= TICK_LOAD;
               state <= WAIT_TICK;
            end
            default: begin
               plot_valid <= 1'b0;
               state      <= WAIT_TICK;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enemy_engine.sv
// Scoreboard bench for enemy_engine: stimulus queues expected pixels, a monitor checks them.
module tb_enemy_engine;

   typedef struct {
      int slot;
      int col;
      int row;
      int xb;
      int yb;
      int c;
      bit draw;
      bit sp;
      bit after;
   } pix_t;

   logic       clock = 1'b0;
   logic       resetn;
   logic       enable;
   logic [1:0] kill;
   logic       plot_ready;
   logic       plot_valid;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       frame_done;
   logic [1:0] kill_ack;

   int   total = 0;
   int   bad = 0;
   int   cyc;
   logic [7:0] ref_lfsr;
   logic [7:0] lf_prev;
   pix_t exp_q[$];
   int   sp_x[2];
   int   sp_c[2];
   int   ack_cnt[2];

   int m_ex[2];
   int m_ey[2];
   int m_c[2];
   bit m_kill[2];
   bit m_sp[2];

   always #5 clock = ~clock;

   enemy_engine #(
      .N_ENEMY    (2),
      .SPR_W      (2),
      .SPR_H      (2),
      .X_MAX      (160),
      .Y_MAX      (120),
      .TICK_CYCLES(8),
      .STEP       (1),
      .SEED       (8'hA5)
   ) dut (
      .clock     (clock),
      .resetn    (resetn),
      .enable    (enable),
      .kill      (kill),
      .plot_ready(plot_ready),
      .plot_valid(plot_valid),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .frame_done(frame_done),
      .kill_ack  (kill_ack)
   );

   // Reference LFSR: x^8+x^6+x^5+x^4+1, one step per clock out of reset.
   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cyc      <= 0;
         ref_lfsr <= 8'hA5;
      end else begin
         cyc      <= cyc + 1;
         ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
      end
   end

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int spawn_x_of(input logic [7:0] v);
      return (v < 8'd158) ? int'(v) : int'(v) - 158;
   endfunction

   function automatic int spawn_c_of(input logic [7:0] v);
      return (v[2:0] == 3'b000) ? 7 : int'(v[2:0]);
   endfunction

   // Monitor: checks each transferred pixel and holds during stalls.
   initial begin
      pix_t       e;
      logic       stall;
      logic [7:0] sx;
      logic [6:0] sy;
      logic [2:0] sc;
      int         bx;
      int         bc;
      string      tag;
      stall = 1'b0;
      sx = '0;
      sy = '0;
      sc = '0;
      lf_prev = 8'hA5;
      forever begin
         @(negedge clock);
         if (resetn) begin
            if (stall) begin
               check("stall hold x", int'(x), int'(sx));
               check("stall hold y", int'(y), int'(sy));
               check("stall hold colour", int'(colour), int'(sc));
            end
            stall = plot_valid && !plot_ready;
            sx = x;
            sy = y;
            sc = colour;
            for (int i = 0; i < 2; i++) ack_cnt[i] += int'(kill_ack[i]);
            if (plot_valid && plot_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected pixel", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  tag = $sformatf("slot%0d %s px(%0d,%0d)", e.slot, e.draw ? "draw" : "erase",
                                  e.col, e.row);
                  if (e.sp && e.col == 0 && e.row == 0) begin
                     sp_x[e.slot] = spawn_x_of(lf_prev);
                     sp_c[e.slot] = spawn_c_of(lf_prev);
                     check({tag, " spawn colour nonzero"}, int'(colour != 3'b000), 1);
                     check({tag, " spawn x below 158"}, int'(x < 8'd158), 1);
                  end
                  bx = (e.sp || e.after) ? sp_x[e.slot] : e.xb;
                  bc = !e.draw ? 0 : ((e.sp || e.after) ? sp_c[e.slot] : e.c);
                  check({tag, " x"}, int'(x), bx + e.col);
                  check({tag, " y"}, int'(y), e.yb + e.row);
                  check({tag, " colour"}, int'(colour), bc);
               end
            end
         end else begin
            stall = 1'b0;
         end
         lf_prev = ref_lfsr;
      end
   end

   task automatic model_reset();
      m_ex[0] = 0;
      m_ex[1] = 80;
      for (int i = 0; i < 2; i++) begin
         m_ey[i]   = 0;
         m_c[i]    = 4;
         m_kill[i] = 1'b0;
         m_sp[i]   = 1'b0;
      end
   endtask

   task automatic push_sprite(input int s, input bit draw, input bit sp, input bit after);
      pix_t p;
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 2; c++) begin
            p.slot  = s;
            p.col   = c;
            p.row   = r;
            p.xb    = m_ex[s];
            p.yb    = m_ey[s];
            p.c     = m_c[s];
            p.draw  = draw;
            p.sp    = sp;
            p.after = after;
            exp_q.push_back(p);
         end
      end
   endtask

   // Queue one full pass; respawn when killed or when ey+1 exceeds 120-2.
   task automatic push_pass();
      bit now;
      for (int s = 0; s < 2; s++) begin
         push_sprite(s, 1'b0, 1'b0, m_sp[s]);
         now = 1'b0;
         if (m_kill[s] || (m_ey[s] + 1 > 118)) begin
            m_ey[s]   = 0;
            m_kill[s] = 1'b0;
            m_sp[s]   = 1'b1;
            now       = 1'b1;
         end else begin
            m_ey[s] = m_ey[s] + 1;
         end
         push_sprite(s, 1'b1, now, m_sp[s] && !now);
      end
   endtask

   task automatic wait_valid(input string name, output int c);
      c = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (plot_valid) begin
            c = cyc + 1;
            break;
         end
      end
      if (c < 0) check({name, " plot_valid timeout"}, 0, 1);
   endtask

   task automatic wait_frame(input string name, output int c);
      c = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (frame_done) begin
            c = cyc + 1;
            break;
         end
      end
      if (c < 0) check({name, " frame_done timeout"}, 0, 1);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, " plot_valid"}, int'(plot_valid), 0);
      check({name, " x"}, int'(x), 0);
      check({name, " y"}, int'(y), 0);
      check({name, " colour"}, int'(colour), 0);
      check({name, " frame_done"}, int'(frame_done), 0);
      check({name, " kill_ack"}, int'(kill_ack), 0);
   endtask

   initial begin
      int vc;
      int fc;
      int ec;
      int guard;
      bit seen;
      resetn     = 1'b0;
      enable     = 1'b1;
      kill       = 2'b00;
      plot_ready = 1'b1;
      ack_cnt[0] = 0;
      ack_cnt[1] = 0;
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("reset");

      // Pass 1: reset positions, latency and pass length.
      model_reset();
      push_pass();
      resetn = 1'b1;
      wait_valid("pass1", vc);
      check("pass1 first plot_valid cycle", vc, 9);
      wait_frame("pass1", fc);
      check("pass1 frame_done cycle", fc, 29);
      check("pass1 queue drained", exp_q.size(), 0);

      // Pass 2: stall two cycles during ERASE.
      push_pass();
      wait_valid("pass2", vc);
      check("pass2 first plot_valid cycle", vc, 38);
      @(posedge clock);
      #1 plot_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1 plot_ready = 1'b1;
      wait_frame("pass2", fc);
      check("pass2 length with stall", fc - vc, 22);
      check("pass2 queue drained", exp_q.size(), 0);

      // Pass 3: kill slot 1 while waiting for the tick.
      ack_cnt[0] = 0;
      ack_cnt[1] = 0;
      @(posedge clock);
      #1 kill = 2'b10;
      @(posedge clock);
      #1 kill = 2'b00;
      m_kill[1] = 1'b1;
      push_pass();
      wait_frame("pass3", fc);
      check("pass3 kill_ack[1] pulses", ack_cnt[1], 1);
      check("pass3 kill_ack[0] pulses", ack_cnt[0], 0);
      check("pass3 queue drained", exp_q.size(), 0);

      // Pass 4: enable held low for 50 cycles with the counter at 4.
      push_pass();
      repeat (4) @(posedge clock);
      #1 enable = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (plot_valid) seen = 1'b1;
      end
      check("enable low plot_valid seen", int'(seen), 0);
      @(posedge clock);
      #1 enable = 1'b1;
      ec = cyc + 1;
      wait_valid("pass4", vc);
      check("pass4 resume delay", vc - ec, 5);
      wait_frame("pass4", fc);
      check("pass4 queue drained", exp_q.size(), 0);

      // Run until slot 0 walks off the bottom and respawns.
      ack_cnt[0] = 0;
      ack_cnt[1] = 0;
      guard = 0;
      while (!m_sp[0] && guard < 130) begin
         push_pass();
         wait_frame("walk", fc);
         guard++;
      end
      check("walk kill_ack[0] pulses", ack_cnt[0], 0);
      check("walk kill_ack[1] pulses", ack_cnt[1], 0);
      check("walk queue drained", exp_q.size(), 0);

      // Reset during slot 0 DRAW.
      push_pass();
      wait_valid("midreset", vc);
      repeat (5) @(posedge clock);
      #2 resetn = 1'b0;
      #1;
      check_reset_outputs("midreset");
      exp_q.delete();
      model_reset();
      repeat (2) @(posedge clock);
      check("midreset plot_valid held", int'(plot_valid), 0);
      push_pass();
      #1 resetn = 1'b1;
      wait_valid("after reset", vc);
      check("after reset first plot_valid cycle", vc, 9);
      wait_frame("after reset", fc);
      check("after reset frame_done cycle", fc, 29);
      check("after reset queue drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
